// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and FSM states for the writeback stage
package wb_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 7;
  localparam int NUM_REGS   = 128;

  typedef enum logic {
    INIT,
    RUN
  } wbState_t;

endpackage

// File: rtl/regfile_128x32.sv
// rtl/regfile_128x32.sv - one write port, two async read ports, reg0 reads zero
module regfile_128x32
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0]     wData,
  input  logic [REG_ADDR_W-1:0] rAddr1,
  input  logic [REG_ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0]     rData1,
  output logic [DATA_W-1:0]     rData2
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  // Entry 0 may hold anything; the read mux hides it.
  assign rData1 = (rAddr1 == '0) ? '0 : mem[rAddr1];
  assign rData2 = (rAddr2 == '0) ? '0 : mem[rAddr2];

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, register file clear sequencer and read bypass
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wr_en,
  input  logic [REG_ADDR_W-1:0] mem_branch,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_wr_en,
  output logic [REG_ADDR_W-1:0] branch_out,
  output logic                  ready
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  wbState_t              state;
  wbState_t              stateNext;
  logic [REG_ADDR_W-1:0] initCnt;
  logic [REG_ADDR_W-1:0] initCntNext;

  logic                  rfWe;
  logic [REG_ADDR_W-1:0] rfWAddr;
  logic [DATA_W-1:0]     rfWData;
  logic [DATA_W-1:0]     rfData1;
  logic [DATA_W-1:0]     rfData2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      initCnt <= '0;
    end else begin
      state   <= stateNext;
      initCnt <= initCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    if (state == INIT) begin
      initCntNext = initCnt + 1'b1;
      if (initCnt == LAST_IDX) begin
        stateNext = RUN;
      end
    end
  end

  // While clearing, the pipeline register is held at its flushed value so stray MEM traffic is dropped.
  always_ff @(posedge clk) begin
    if (rst || (state == INIT) || flush) begin
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_wr_en   <= 1'b0;
      branch_out <= '0;
    end else if (!stall) begin
      wb_rd      <= mem_rd;
      wb_data    <= mem_result;
      wb_wr_en   <= mem_wr_en;
      branch_out <= mem_branch;
    end
  end

  // The write port is shared between the clear sequence and normal commits; reset drops both.
  always_comb begin
    rfWe    = 1'b0;
    rfWAddr = wb_rd;
    rfWData = wb_data;
    if (rst) begin
      rfWe = 1'b0;
    end else if (state == INIT) begin
      rfWe    = 1'b1;
      rfWAddr = initCnt;
      rfWData = '0;
    end else if (wb_wr_en && (wb_rd != '0)) begin
      rfWe = 1'b1;
    end
  end

  regfile_128x32 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) uRegfile (
    .clk    (clk),
    .we     (rfWe),
    .wAddr  (rfWAddr),
    .wData  (rfWData),
    .rAddr1 (rs1_addr),
    .rAddr2 (rs2_addr),
    .rData1 (rfData1),
    .rData2 (rfData2)
  );

  assign ready = (state == RUN);

  assign rs1_data = (state == INIT) ? '0 :
                    (wb_wr_en && (wb_rd == rs1_addr) && (rs1_addr != '0)) ? wb_data : rfData1;
  assign rs2_data = (state == INIT) ? '0 :
                    (wb_wr_en && (wb_rd == rs2_addr) && (rs2_addr != '0)) ? wb_data : rfData2;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage against a register-file model
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] mem_result = '0;
  logic [6:0]  mem_rd = '0;
  logic        mem_wr_en = 1'b0;
  logic [6:0]  mem_branch = '0;
  logic [6:0]  rs1_addr = '0;
  logic [6:0]  rs2_addr = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [6:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_wr_en;
  logic [6:0]  branch_out;
  logic        ready;

  int nChecks = 0;
  int nFails  = 0;

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .mem_result (mem_result),
    .mem_rd     (mem_rd),
    .mem_wr_en  (mem_wr_en),
    .mem_branch (mem_branch),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_wr_en   (wb_wr_en),
    .branch_out (branch_out),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Reference: architectural register contents, remaining clear cycles, and the one in-flight result.
  logic [31:0] mRegs [128];
  int          mInitLeft = 128;
  logic        mWrEn = 1'b0;
  logic [6:0]  mRd = '0;
  logic [31:0] mData = '0;
  logic [6:0]  mBranch = '0;

  function void modelEdge();
    if (rst) begin
      mInitLeft = 128;
      mWrEn = 1'b0; mRd = '0; mData = '0; mBranch = '0;
    end else if (mInitLeft > 0) begin
      mInitLeft--;
      if (mInitLeft == 0) foreach (mRegs[i]) mRegs[i] = '0;
      mWrEn = 1'b0; mRd = '0; mData = '0; mBranch = '0;
    end else begin
      if (mWrEn && mRd != 0) mRegs[mRd] = mData;
      if (flush) begin
        mWrEn = 1'b0; mRd = '0; mData = '0; mBranch = '0;
      end else if (!stall) begin
        mWrEn = mem_wr_en; mRd = mem_rd; mData = mem_result; mBranch = mem_branch;
      end
    end
  endfunction

  function logic [31:0] expRead(input logic [6:0] addr);
    if (mInitLeft > 0 || addr == 0) return '0;
    if (mWrEn && mRd == addr) return mData;
    return mRegs[addr];
  endfunction

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (wb_wr_en !== 1'b0 || wb_rd !== 7'd0 || wb_data !== 32'd0 || branch_out !== 7'd0) begin
      $display("FAIL reset_wb: got en=%b rd=%0d data=%h br=%0d expected all zero", wb_wr_en, wb_rd, wb_data, branch_out);
      nFails++;
    end
    nChecks++;
    for (int i = 0; i < 128; i++) begin
      mem_wr_en  = 1'b1;
      mem_rd     = 7'($urandom_range(1, 127));
      mem_result = $urandom;
      mem_branch = 7'($urandom);
      rs1_addr   = 7'd5;
      rs2_addr   = mem_rd;
      #1;
      if (ready !== 1'b0) begin
        $display("FAIL init_ready: cycle %0d got %b expected 0", i, ready);
        nFails++;
      end
      nChecks++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
        $display("FAIL init_read: cycle %0d got %h/%h expected 0", i, rs1_data, rs2_data);
        nFails++;
      end
      nChecks++;
      tick();
    end
    mem_wr_en = 1'b0;
    if (ready !== 1'b1) begin
      $display("FAIL init_done: got ready=%b expected 1", ready);
      nFails++;
    end
    nChecks++;
    for (int a = 0; a < 128; a++) begin
      rs1_addr = 7'(a);
      rs2_addr = 7'(127 - a);
      #1;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
        $display("FAIL init_cleared: r%0d/r%0d got %h/%h expected 0", a, 127 - a, rs1_data, rs2_data);
        nFails++;
      end
      nChecks++;
    end
  endtask

  task automatic test_write_read();
    mem_rd = 7'd12; mem_result = 32'h0000_00AB; mem_wr_en = 1'b1; mem_branch = 7'd33;
    tick();
    mem_wr_en = 1'b0; rs1_addr = 7'd12; rs2_addr = 7'd13;
    #1;
    if (rs1_data !== 32'h0000_00AB) begin
      $display("FAIL write_bypass: got %h expected 000000ab", rs1_data);
      nFails++;
    end
    nChecks++;
    if (branch_out !== 7'd33 || wb_rd !== 7'd12) begin
      $display("FAIL write_wbreg: got br=%0d rd=%0d expected 33/12", branch_out, wb_rd);
      nFails++;
    end
    nChecks++;
    tick();
    if (rs1_data !== 32'h0000_00AB || wb_wr_en !== 1'b0) begin
      $display("FAIL write_file: got %h en=%b expected 000000ab en=0", rs1_data, wb_wr_en);
      nFails++;
    end
    nChecks++;
  endtask

  task automatic test_reg_zero();
    mem_rd = 7'd0; mem_result = 32'hFFFF_FFFF; mem_wr_en = 1'b1;
    tick();
    mem_wr_en = 1'b0; rs1_addr = 7'd0; rs2_addr = 7'd0;
    #1;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      $display("FAIL zero_bypass: got %h/%h expected 0", rs1_data, rs2_data);
      nFails++;
    end
    nChecks++;
    tick();
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      $display("FAIL zero_file: got %h/%h expected 0", rs1_data, rs2_data);
      nFails++;
    end
    nChecks++;
  endtask

  task automatic test_stall_flush();
    logic [31:0] holdData;
    logic [6:0]  holdBr;
    holdData = $urandom;
    holdBr   = 7'($urandom);
    mem_rd = 7'd9; mem_result = holdData; mem_wr_en = 1'b1; mem_branch = holdBr;
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      mem_rd = 7'($urandom_range(1, 127)); mem_result = $urandom;
      mem_wr_en = 1'($urandom); mem_branch = 7'($urandom);
      tick();
      if (wb_rd !== 7'd9 || wb_data !== holdData || wb_wr_en !== 1'b1 || branch_out !== holdBr) begin
        $display("FAIL stall_hold: cycle %0d got rd=%0d data=%h en=%b br=%0d expected 9/%h/1/%0d",
                 i, wb_rd, wb_data, wb_wr_en, branch_out, holdData, holdBr);
        nFails++;
      end
      nChecks++;
    end
    stall = 1'b1; flush = 1'b1;
    mem_rd = 7'd20; mem_result = 32'hDEAD_BEEF; mem_wr_en = 1'b1; mem_branch = 7'd99;
    tick();
    if (wb_wr_en !== 1'b0 || branch_out !== 7'd0 || wb_rd !== 7'd0 || wb_data !== 32'd0) begin
      $display("FAIL flush_prio: got en=%b br=%0d rd=%0d data=%h expected zeros", wb_wr_en, branch_out, wb_rd, wb_data);
      nFails++;
    end
    nChecks++;
    stall = 1'b0; flush = 1'b0; mem_wr_en = 1'b0;
    tick();
    rs1_addr = 7'd20; rs2_addr = 7'd9;
    #1;
    if (rs1_data !== 32'd0) begin
      $display("FAIL flush_nowrite: got %h expected 0", rs1_data);
      nFails++;
    end
    nChecks++;
    if (rs2_data !== holdData) begin
      $display("FAIL stall_commit: got %h expected %h", rs2_data, holdData);
      nFails++;
    end
    nChecks++;
  endtask

  task automatic test_reset_mid_run();
    mem_rd = 7'd7; mem_result = 32'h55; mem_wr_en = 1'b1;
    tick();
    mem_rd = 7'd8; mem_result = 32'h66;
    tick();
    mem_wr_en = 1'b0; rs1_addr = 7'd7;
    #1;
    if (rs1_data !== 32'h55) begin
      $display("FAIL midrst_pre: got %h expected 55", rs1_data);
      nFails++;
    end
    nChecks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (ready !== 1'b0) begin
        $display("FAIL midrst_ready: cycle %0d got %b expected 0", i, ready);
        nFails++;
      end
      nChecks++;
      tick();
    end
    rs1_addr = 7'd7; rs2_addr = 7'd8;
    #1;
    if (ready !== 1'b1 || rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      $display("FAIL midrst_post: got ready=%b r7=%h r8=%h expected 1/0/0", ready, rs1_data, rs2_data);
      nFails++;
    end
    nChecks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] seqVals [3];
    seqVals[0] = 32'd1; seqVals[1] = 32'd2; seqVals[2] = 32'd3;
    rs1_addr = 7'd3; rs2_addr = 7'd3;
    for (int i = 0; i < 3; i++) begin
      mem_rd = 7'd3; mem_result = seqVals[i]; mem_wr_en = 1'b1;
      tick();
      if (rs1_data !== seqVals[i] || rs2_data !== seqVals[i]) begin
        $display("FAIL b2b_track: step %0d got %h/%h expected %h", i, rs1_data, rs2_data, seqVals[i]);
        nFails++;
      end
      nChecks++;
    end
    mem_wr_en = 1'b0;
    tick();
    if (rs1_data !== 32'd3 || rs2_data !== 32'd3 || wb_wr_en !== 1'b0) begin
      $display("FAIL b2b_final: got %h/%h en=%b expected 3/3/0", rs1_data, rs2_data, wb_wr_en);
      nFails++;
    end
    nChecks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      stall      = ($urandom_range(0, 99) < 25);
      flush      = ($urandom_range(0, 99) < 10);
      mem_wr_en  = ($urandom_range(0, 99) < 70);
      mem_rd     = 7'($urandom_range(0, 15));
      mem_result = $urandom;
      mem_branch = 7'($urandom);
      rs1_addr   = 7'($urandom_range(0, 15));
      rs2_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : 7'($urandom_range(0, 15));
      #1;
      if (rs1_data !== expRead(rs1_addr) || rs2_data !== expRead(rs2_addr) || ready !== (mInitLeft == 0)) begin
        $display("FAIL rand_read: cycle %0d a=%0d/%0d got %h/%h rdy=%b expected %h/%h rdy=%b", i, rs1_addr, rs2_addr,
                 rs1_data, rs2_data, ready, expRead(rs1_addr), expRead(rs2_addr), mInitLeft == 0);
        nFails++;
      end
      nChecks++;
      tick();
      if (wb_wr_en !== mWrEn || wb_rd !== mRd || wb_data !== mData || branch_out !== mBranch) begin
        $display("FAIL rand_wb: cycle %0d got en=%b rd=%0d data=%h br=%0d expected en=%b rd=%0d data=%h br=%0d",
                 i, wb_wr_en, wb_rd, wb_data, branch_out, mWrEn, mRd, mData, mBranch);
        nFails++;
      end
      nChecks++;
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; mem_wr_en = 1'b0;
    for (int i = 0; i < 130; i++) tick();
    for (int a = 0; a < 16; a++) begin
      rs1_addr = 7'(a);
      rs2_addr = 7'(15 - a);
      #1;
      if (rs1_data !== expRead(rs1_addr) || rs2_data !== expRead(rs2_addr)) begin
        $display("FAIL rand_final: r%0d/r%0d got %h/%h expected %h/%h", a, 15 - a, rs1_data, rs2_data,
                 expRead(rs1_addr), expRead(rs2_addr));
        nFails++;
      end
      nChecks++;
    end
  endtask

  initial begin
    foreach (mRegs[i]) mRegs[i] = '0;
    test_reset();
    test_write_read();
    test_reg_zero();
    test_stall_flush();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the result and register data width.
REQ-002 SHALL have parameter NUM_REGS, default 128, the register count, addressed by 7 bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold the MEM/WB register
- flush  in  1  squash the incoming MEM result
- mem_result  in  32  load data or ALU result from the MEM stage
- mem_rd  in  7  destination register from the MEM stage
- mem_wr_en  in  1  write request from the MEM stage
- mem_branch  in  7  branch result from the MEM stage
- rs1_addr, rs2_addr  in  7 each  decode read addresses
- rs1_data, rs2_data  out  32 each  read data
- wb_rd  out  7  registered destination
- wb_data  out  32  registered write data
- wb_wr_en  out  1  registered write enable
- branch_out  out  7  registered branch result
- ready  out  1  register file initialised

Function
REQ-005 SHALL implement a two-state FSM {INIT, RUN}; reset enters INIT with init counter = 0.
REQ-006 In INIT, SHALL write 0 to register[init counter] each cycle and increment the counter.
REQ-007 SHALL move from INIT to RUN after writing index NUM_REGS-1, so INIT lasts exactly 128 cycles.
REQ-008 ready SHALL be 0 in INIT and 1 in RUN.
REQ-009 In RUN with stall=0, flush=0, the MEM/WB register SHALL capture mem_result, mem_rd, mem_wr_en and mem_branch at each rising edge.
REQ-010 With flush=1, SHALL capture wb_wr_en=0, wb_rd=0, wb_data=0 and branch_out=0; flush has priority over stall.
REQ-011 With stall=1 and flush=0, the MEM/WB register SHALL hold its value.
REQ-012 In INIT, the MEM/WB register SHALL be forced to the flushed value, so inputs are ignored.
REQ-013 When wb_wr_en=1 and wb_rd!=0, SHALL write wb_data into register[wb_rd] at the next rising edge; a write to address 0 SHALL be discarded.
REQ-014 Latency: an input captured at edge N SHALL be committed to the file at edge N+1.
REQ-015 Reads SHALL be combinational. Register 0 always reads 0.
REQ-016 If wb_wr_en=1, wb_rd=rsX_addr and rsX_addr!=0, rsX_data SHALL equal wb_data (bypass); otherwise it SHALL be the stored value.
REQ-017 Both read ports SHALL bypass independently when rs1_addr=rs2_addr.
REQ-018 rs1_data and rs2_data SHALL read 0 during INIT.
REQ-019 No width conversion is performed; data passes through unchanged at 32 bits.

Reset
REQ-020 rst=1 at an edge SHALL clear wb_rd, wb_data, wb_wr_en, branch_out and ready, and set state=INIT, counter=0.
REQ-021 rst asserted mid-INIT or mid-RUN SHALL restart the full 128-cycle clear.
REQ-022 A pending write SHALL be discarded when rst=1 coincides with it.

Structure
REQ-023 Package wb_pkg SHALL hold DATA_W, REG_ADDR_W=7, NUM_REGS=128 and the state enum {INIT, RUN}.
REQ-024 The register array SHALL be a sub-module regfile_128x32 with 1 write port, 2 async read ports and reg0 forced to zero.
REQ-025 Bypass, the FSM and the MEM/WB register SHALL reside in wb_stage.

Verification
REQ-026 Reset: rst high 1 cycle, then low; ready=0 for 128 cycles, then 1. Reading r5 during INIT returns 0. Raise mem_wr_en during INIT; no write occurs.
REQ-027 Write/read: mem_rd=12, mem_result=0x000000AB, mem_wr_en=1 at edge N.
- rs1_addr=12 returns 0xAB between N and N+1 via bypass.
- rs1_addr=12 still returns 0xAB after N+1 from the file.
REQ-028 Register zero: write 0xFFFFFFFF to rd=0; rs1_addr=0 and rs2_addr=0 both return 0, including during the bypass window.
REQ-029 Stall/flush:
- stall=1 for 3 cycles: wb_* and branch_out hold.
- stall=1 with flush=1: wb_wr_en=0 and branch_out=0 next cycle, and no file write occurs.
REQ-030 Reset mid-RUN: write r7=0x55, assert rst; after 128 cycles r7 reads 0 and ready=1.
REQ-031 Back-to-back: writes r3=1, r3=2, r3=3 on consecutive edges; rs1 and rs2 both on r3 track the values each cycle; final stored value is 3.
